// File: rtl/compare_seq_pkg.sv
// Shared types and helpers for the sequential multi-word comparator.
package compare_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    RES_LT,
    RES_EQ,
    RES_GT
  } result_t;

  // Counter width for an index spanning n words; never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/compare.sv
// Narrow unsigned magnitude comparator; combinational.
module compare #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            gt,
  output logic            eq
);

  assign gt = (a > b);
  assign eq = (a == b);

endmodule

// File: rtl/compare_seq.sv
// Wide unsigned comparator that walks its operands one word per cycle, MSW first.
// Build option: COMPARE_SEQ_EARLY_EXIT_EN stops on the first unequal word.
module compare_seq
  import compare_seq_pkg::*;
#(
  parameter int WORD_SIZE = 4,
  parameter int NUM_WORDS = 4,
  localparam int WIDTH = WORD_SIZE * NUM_WORDS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int IDX_W = idx_width(NUM_WORDS);
  localparam logic [IDX_W-1:0] IDX_INIT = IDX_W'(NUM_WORDS - 1);

  // Handshake: start is taken only in IDLE; done pulses one cycle and the
  // result flags then hold until the next accepted start.
  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             decided;

  logic [WORD_SIZE-1:0] word_a;
  logic [WORD_SIZE-1:0] word_b;
  logic                 w_gt;
  logic                 w_eq;
  result_t              word_res;
  logic                 last_step;

  always_comb begin
    word_a = '0;
    word_b = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (idx == IDX_W'(i)) begin
        word_a = a_r[i*WORD_SIZE +: WORD_SIZE];
        word_b = b_r[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  compare #(
    .SIZE(WORD_SIZE)
  ) u_compare (
    .a (word_a),
    .b (word_b),
    .gt(w_gt),
    .eq(w_eq)
  );

  always_comb begin
    if (w_eq)
      word_res = RES_EQ;
    else if (w_gt)
      word_res = RES_GT;
    else
      word_res = RES_LT;
  end

`ifdef COMPARE_SEQ_EARLY_EXIT_EN
  assign last_step = (word_res != RES_EQ) || (idx == '0);
`else
  assign last_step = (idx == '0);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      idx     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      decided <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      gt      <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            idx     <= IDX_INIT;
            gt      <= 1'b0;
            eq      <= 1'b0;
            lt      <= 1'b0;
            decided <= 1'b0;
            busy    <= 1'b1;
            state   <= COMPARE;
          end
        end
        COMPARE: begin
          // The first unequal word fixes the answer; later words cannot change it.
          if (!decided && (word_res != RES_EQ)) begin
            gt      <= (word_res == RES_GT);
            lt      <= (word_res == RES_LT);
            decided <= 1'b1;
          end
          if (last_step) begin
            if (!decided && (word_res == RES_EQ))
              eq <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
